// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the hazard unit: forwarding select codes,
// the shadow slot layout, and the slot writer/match helper.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // EX operand mux select codes
  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,  // ID/EX register-file operand
    FWD_MEM  = 2'd1,  // EX/MEM ALU result
    FWD_WB   = 2'd2,  // MEM/WB result
    FWD_HOLD = 2'd3   // value retired one cycle ago (no register-file write-through)
  } fwd_sel_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  ld;
  } hazard_slot_t;

  // True when the slot holds a real write to a non-zero rd equal to rs.
  function automatic logic slot_hit(hazard_slot_t slot, logic [REG_ADDR_W-1:0] rs);
    return slot.valid && slot.we && (slot.rd != '0) && (slot.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the four shadow slots and
// returns the operand select plus a stall request.
// HAZARD_FWD_EN: when defined, matches resolve by forwarding (only a
// load in EX stalls); otherwise any match stalls and the select is 0.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  use_i,
  input  hazard_slot_t          ex_i,
  input  hazard_slot_t          mem_i,
  input  hazard_slot_t          wb_i,
  input  hazard_slot_t          hold_i,
  output fwd_sel_e              sel_o,
  output logic                  stall_o
);

`ifdef HAZARD_FWD_EN
  // Hold slot is already visible through the register file in this mode.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_i.ld, wb_i.ld, hold_i};
`else
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_i.ld, mem_i.ld, wb_i.ld, hold_i.ld};
`endif

  // Youngest-first priority search over the in-flight writers.
  always_comb begin
    sel_o   = FWD_REG;
    stall_o = 1'b0;
    if (use_i && (rs_i != '0)) begin
`ifdef HAZARD_FWD_EN
      if (slot_hit(ex_i, rs_i)) begin
        if (ex_i.ld) begin
          stall_o = 1'b1;
        end else begin
          sel_o = FWD_MEM;
        end
      end else if (slot_hit(mem_i, rs_i)) begin
        sel_o = FWD_WB;
      end else if (slot_hit(wb_i, rs_i)) begin
        sel_o = FWD_HOLD;
      end
`else
      stall_o = slot_hit(ex_i, rs_i) || slot_hit(mem_i, rs_i) ||
                slot_hit(wb_i, rs_i) || slot_hit(hold_i, rs_i);
`endif
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: shadows the destination fields of in-flight
// instructions, generates registered EX operand selects and the
// stall/bubble controls. Forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_load_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o
);

  hazard_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, hold_q, hold_d;
  fwd_sel_e     fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_e     sel_a, sel_b;
  logic         stall_a, stall_b;

  hazard_match u_match_a (
    .rs_i    (id_rs1_i),
    .use_i   (id_use_rs1_i),
    .ex_i    (ex_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .hold_i  (hold_q),
    .sel_o   (sel_a),
    .stall_o (stall_a)
  );

  hazard_match u_match_b (
    .rs_i    (id_rs2_i),
    .use_i   (id_use_rs2_i),
    .ex_i    (ex_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .hold_i  (hold_q),
    .sel_o   (sel_b),
    .stall_o (stall_b)
  );

  // Stall only for a real instruction; a redirect overrides the stall.
  always_comb begin
    stall_o  = id_valid_i && (stall_a || stall_b) && !flush_i;
    bubble_o = stall_o || flush_i;
  end

  // Shift the shadow slots and compute the next operand selects.
  always_comb begin
    mem_d  = ex_q;
    wb_d   = mem_q;
    hold_d = wb_q;

    ex_d       = '0;
    if (!bubble_o) begin
      ex_d.valid = id_valid_i;
      ex_d.rd    = id_rd_i;
      ex_d.we    = id_we_i;
      ex_d.ld    = id_load_i;
    end

    fwd_a_d = (bubble_o || !id_valid_i) ? FWD_REG : sel_a;
    fwd_b_d = (bubble_o || !id_valid_i) ? FWD_REG : sel_b;
  end

  // Slot and select registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      hold_q  <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      hold_q  <= hold_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit. Expected stall/bubble values are
// queued when an ID instruction is driven and popped at the mid-cycle
// sample; expected selects are queued for the following (EX) cycle.
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  logic       id_we_i, id_load_i, flush_i;
  logic       stall_o, bubble_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [1:0] ctl_q[$];  // {stall, bubble} for the current cycle
  logic [3:0] sel_q[$];  // {sel_a, sel_b} for the cycle after issue

  hazard_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_we_i      (id_we_i),
    .id_load_i    (id_load_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .bubble_o     (bubble_o),
    .fwd_a_sel_o  (fwd_a_sel_o),
    .fwd_b_sel_o  (fwd_b_sel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive ID, queue expectations, sample at negedge, advance.
  task automatic step(input string tag, input bit v, input logic [4:0] rs1, input bit u1,
                      input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                      input bit we, input bit ld, input bit fl, input bit rs,
                      input bit es, input logic [1:0] ea, input logic [1:0] eb);
    logic [1:0] ctl;
    logic [3:0] sel;
    id_valid_i   = v;
    id_rs1_i     = rs1;
    id_use_rs1_i = u1;
    id_rs2_i     = rs2;
    id_use_rs2_i = u2;
    id_rd_i      = rd;
    id_we_i      = we;
    id_load_i    = ld;
    flush_i      = fl;
    rst_i        = rs;
    ctl_q.push_back({es, es | fl});
    @(negedge clk_i);
    ctl = ctl_q.pop_front();
    check_eq({tag, ".stall"}, {7'd0, stall_o}, {7'd0, ctl[1]});
    check_eq({tag, ".bubble"}, {7'd0, bubble_o}, {7'd0, ctl[0]});
    sel = sel_q.pop_front();
    check_eq({tag, ".sel_a"}, {6'd0, fwd_a_sel_o}, {6'd0, sel[3:2]});
    check_eq({tag, ".sel_b"}, {6'd0, fwd_b_sel_o}, {6'd0, sel[1:0]});
    // A stalled, flushed or reset cycle leaves a bubble in EX.
    if (es || fl || rs) sel_q.push_back(4'd0);
    else                sel_q.push_back({ea, eb});
    @(posedge clk_i);
    #1;
  endtask

  task automatic ins(input string tag, input logic [4:0] rs1, input bit u1,
                     input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                     input bit we, input bit ld, input bit es,
                     input logic [1:0] ea, input logic [1:0] eb);
    step(tag, 1'b1, rs1, u1, rs2, u2, rd, we, ld, 1'b0, 1'b0, es, ea, eb);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    int n;
    rst_i = 1'b1; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; id_we_i = 1'b0; id_load_i = 1'b0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sel_q.push_back(4'd0);
    step("reset", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // addi x1 ; add x2,x1,x1
    ins("addi_x1", 5'd0, 1, 5'd0, 0, 5'd1, 1, 0, 0, 2'd0, 2'd0);
    n = Fwd ? 0 : 4;
    for (int i = 0; i < n; i++) ins("raw_stall", 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 1, 2'd0, 2'd0);
    ins("raw_go", 5'd1, 1, 5'd1, 1, 5'd2, 1, 0, 0, Fwd ? 2'd1 : 2'd0, Fwd ? 2'd1 : 2'd0);
    drain("drain1");

    // Writer x3, two independent, reader x3
    ins("w_x3", 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 2'd0, 2'd0);
    ins("ind_a", 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 2'd0, 2'd0);
    ins("ind_b", 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 0, 2'd0, 2'd0);
    n = Fwd ? 0 : 2;
    for (int i = 0; i < n; i++) ins("gap2_stall", 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 1, 2'd0, 2'd0);
    ins("gap2_go", 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 0, Fwd ? 2'd3 : 2'd0, 2'd0);
    drain("drain2");

    // Writer x3, one independent, reader x3 (on operand b)
    ins("w_x3b", 5'd0, 0, 5'd0, 0, 5'd3, 1, 0, 0, 2'd0, 2'd0);
    ins("ind_c", 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 2'd0, 2'd0);
    n = Fwd ? 0 : 3;
    for (int i = 0; i < n; i++) ins("gap1_stall", 5'd0, 1, 5'd3, 1, 5'd9, 1, 0, 1, 2'd0, 2'd0);
    ins("gap1_go", 5'd0, 1, 5'd3, 1, 5'd9, 1, 0, 0, 2'd0, Fwd ? 2'd2 : 2'd0);
    drain("drain3");

    // lw x5 ; add x6,x5,x0
    ins("lw_x5", 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 2'd0, 2'd0);
    n = Fwd ? 1 : 4;
    for (int i = 0; i < n; i++) ins("lu_stall", 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 1, 2'd0, 2'd0);
    ins("lu_go", 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, Fwd ? 2'd2 : 2'd0, 2'd0);
    drain("drain4");

    // x0 writer (as a load) then x0 reader
    ins("w_x0", 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 2'd0, 2'd0);
    ins("r_x0", 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0, 2'd0, 2'd0);
    drain("drain5");

    // Load-use coinciding with flush; flushed rd must not match, load still retires
    ins("lw_x5f", 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 2'd0, 2'd0);
    step("lu_flush", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0,
         1'b0, 2'd0, 2'd0);
    ins("r_x6", 5'd6, 1, 5'd0, 0, 5'd10, 1, 0, 0, 2'd0, 2'd0);
    n = Fwd ? 0 : 2;
    for (int i = 0; i < n; i++) ins("r_x5_stall", 5'd5, 1, 5'd0, 0, 5'd11, 1, 0, 1, 2'd0, 2'd0);
    ins("r_x5_go", 5'd5, 1, 5'd0, 0, 5'd11, 1, 0, 0, Fwd ? 2'd3 : 2'd0, 2'd0);
    drain("drain6");

    // Reset during a load-use stall
    ins("lw_x5r", 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 2'd0, 2'd0);
    step("lu_rst", 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1,
         1'b1, 2'd0, 2'd0);
    ins("post_rst", 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 2'd0, 2'd0);
    drain("drain7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Tracks destination registers of in-flight instructions and produces the registered 2-bit operand-select codes that drive the EX-stage 4:1 operand multiplexers, plus the stall/bubble controls for load-use and unresolvable hazards. It sits in the ID stage, directly upstream of the EX operand muxes. It keeps its own shadow of the ID/EX, EX/MEM and MEM/WB destination fields, so the datapath pipeline registers need not export them.

## Interface
- REG_ADDR_W, default 5: register address width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- id_valid_i  in  1  the ID stage holds a real instruction.
- id_rs1_i, id_rs2_i  in  REG_ADDR_W  source register addresses.
- id_use_rs1_i, id_use_rs2_i  in  1  the instruction actually reads rs1/rs2.
- id_rd_i  in  REG_ADDR_W  destination register.
- id_we_i  in  1  the instruction writes rd.
- id_load_i  in  1  the instruction is a load.
- flush_i  in  1  branch/jump redirect; kill ID and EX.
- stall_o  out  1  freeze PC and IF/ID.
- bubble_o  out  1  load NOP into ID/EX.
- fwd_a_sel_o, fwd_b_sel_o  out  2  EX operand mux selects, registered.

## Operation
- Select encoding: 0 = ID/EX register-file operand; 1 = EX/MEM ALU result; 2 = MEM/WB result; 3 = WB-hold register (value retired one cycle ago; the register file has no write-through).
- Shadow slots ex, mem, wb, hold each hold {valid, rd, we, ld}. A slot is a writer only if valid & we & rd != 0.
- Each cycle the slots shift ex→mem→wb→hold. ex loads the ID fields when ID advances, or a bubble (valid = 0) when bubble_o is asserted.
- Per source (only if id_use_rsX_i and rsX != 0), priority is youngest first:
  - ex matches and ex.ld → load-use hazard: stall.
  - ex matches → next sel 1.
  - mem matches → next sel 2.
  - wb matches → next sel 3.
  - otherwise → next sel 0.
- stall_o = id_valid_i & hazard & !flush_i. bubble_o = stall_o | flush_i.
- Selects register into fwd_*_sel_o when ID advances. They are forced to 0 on a bubble.
- flush_i invalidates the incoming ex slot and clears the select registers. The mem, wb and hold slots still retire.
- x0 never forwards and never stalls.

## Timing
- Reset values:
  - stall_o = 0, bubble_o = 0 (both combinational; they evaluate 0 while all slots are invalid).
  - fwd_a_sel_o = fwd_b_sel_o = 0.
  - All slots invalid.
- Select latency: one cycle. A code computed in ID appears on fwd_*_sel_o in the same cycle the instruction is in EX.
- A load-use hazard stalls exactly one cycle with forwarding (select 2 on resume). Without forwarding it stalls until the writer leaves hold.
- When flush_i and a hazard occur together, flush wins: stall_o = 0 and bubble_o = 1.
- Reset asserted mid-stall: the next cycle has stall_o = 0 and all slots are invalid.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above; all four select codes are used.
- HAZARD_FWD_EN undefined: selects are tied to 0. Any match in ex, mem, wb or hold stalls, so a dependent instruction waits until its producer has left hold. Back-to-back dependency costs 4 stall cycles.

## Structure
- Shared package pipeline_pkg:
  - fwd_sel_e enum (FWD_REG = 0, FWD_MEM = 1, FWD_WB = 2, FWD_HOLD = 3).
  - hazard_slot_t struct {valid, rd, we, ld}.
  - REG_ADDR_W default.
- One sub-module, hazard_match: compares one source against the four slots and returns {sel, stall}. It is instantiated twice (rs1, rs2).

## Test plan
- Reset, then addi x1, followed immediately by add x2,x1,x1 → fwd_a_sel_o = fwd_b_sel_o = 1 in the add's EX cycle; no stall.
- Writer of x3, then two independent instructions, then a reader of x3 → reader gets sel 3. With a one-instruction gap it gets sel 2.
- lw x5, then add x6,x5,x0 → stall_o = 1 and bubble_o = 1 for one cycle, then sel_a = 2. Without HAZARD_FWD_EN: 4 stall cycles, then sel_a = 0.
- Writer and reader of x0 → no stall, selects 0.
- Load-use stall with flush_i asserted in the same cycle → stall_o = 0, bubble_o = 1, next selects 0.
- rst_i pulsed during a load-use stall → next cycle stall_o = 0 and selects 0. A subsequent reader of the old rd gets sel 0.
